composite_video_timing: RTL and testbench
=========================================

COMPOSITE_VIDEO_TIMING -- requirements
Module: composite_video_timing

Interface
REQ-001 SHALL have parameter LINE_TICKS_PAL, default 3072, clocks per PAL/SECAM line (64 us at 48 MHz).
REQ-002 SHALL have parameter LINE_TICKS_NTSC, default 3051, clocks per NTSC line.
REQ-003 SHALL have parameter HSYNC_TICKS, default 226, horizontal sync width in clocks.
REQ-004 SHALL have parameter BURST_START, default 269, h position of burst start.
REQ-005 SHALL have parameter ACTIVE_START, default 500, and ACTIVE_WIDTH, default 2400, giving the active pixel window in clocks.
REQ-006 SHALL have parameters VSYNC_LINES, default 3, VBLANK_LINES, default 20, and ACTIVE_LINES, default 240.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-009 SHALL have port video_standard, input, video_standard_e, PAL/NTSC/SECAM selection.
REQ-010 SHALL have outputs sync (1), newframe (1), newline (1), qam_startburst (1) and secam_enabled (1), which feed the encoder.
REQ-011 SHALL have outputs active (1), x (12) and y (9), giving the pixel request to the framebuffer.

Function
REQ-012 SHALL keep h counter 0..LINE_TICKS-1 and v counter 0..LINES-1, where LINES is 312 for PAL/SECAM and 262 for NTSC.
REQ-013 SHALL wrap h to 0 after LINE_TICKS-1 and increment v; at v=LINES-1 and h wrap, v SHALL return to 0.
REQ-014 SHALL latch video_standard only when h=0 and v=0; a mid-frame change SHALL take effect at the next frame start.
REQ-015 SHALL make every output a registered decode of (h,v), so an output is visible one clock after the counter state it decodes.
REQ-016 SHALL assert newline for exactly one clock per line (decode h=0); newframe SHALL assert on the same clock as newline for decode h=0, v=0.
REQ-017 For v>=VSYNC_LINES, sync SHALL be 1 for decode h<HSYNC_TICKS and 0 otherwise.
REQ-018 SHALL pulse qam_startburst for one clock at decode h=BURST_START when v>=VSYNC_LINES and the standard is not SECAM.
REQ-019 SHALL drive secam_enabled=1 when the standard is SECAM, v>=VSYNC_LINES and h>=BURST_START; otherwise 0.
REQ-020 SHALL drive active=1 when ACTIVE_START<=h<ACTIVE_START+ACTIVE_WIDTH and VBLANK_LINES<=v<VBLANK_LINES+ACTIVE_LINES.
REQ-021 When active, x SHALL be h-ACTIVE_START and y SHALL be v-VBLANK_LINES; when not active, both SHALL be 0.
REQ-022 SHALL require no combinational path from any input to any output.

Reset
REQ-023 While rst_n=0 at a clk edge, h, v and every output SHALL become 0, and the latched standard SHALL take video_standard.
REQ-024 On the first edge with rst_n=1, the outputs SHALL show the decode of h=0, v=0 (newframe=newline=sync=1), and h SHALL become 1.
REQ-025 A reset asserted mid-line SHALL abort the frame with no partial pulse after the reset edge.

Configuration
REQ-026 With CONFIG_TIMING_SERRATION_EN defined, on lines v<VSYNC_LINES sync SHALL be 1 for h<LINE_TICKS-HSYNC_TICKS (broad pulses with serration gaps).
REQ-027 Without CONFIG_TIMING_SERRATION_EN, sync SHALL be 1 for the whole of every line v<VSYNC_LINES.

Structure
REQ-028 video_standard_e SHALL be reused from package common, and the per-standard LINES constants SHALL be added to common.
REQ-029 SHALL instantiate one sub-module, timing_counter, holding the h/v counters and wrap logic; decode SHALL stay in the top.

Verification
REQ-030 Reset then PAL: newframe SHALL pulse every 3072*312 = 958464 clocks, with newline every 3072 clocks.
REQ-031 NTSC: newline period SHALL be 3051 clocks and there SHALL be 262 newlines between newframes; qam_startburst SHALL occur 269 clocks after each newline on lines 3..261.
REQ-032 SECAM: qam_startburst SHALL never assert, and secam_enabled SHALL rise at h=269 on line 3.
REQ-033 Switching PAL->NTSC at v=100 SHALL keep the current frame at 312 lines, with the next frame at 262 lines.
REQ-034 The active pixel at line 20, h=500 SHALL give x=0, y=0; at line 259, h=2899 it SHALL give x=2399, y=239; at h=2900, active SHALL be 0.
REQ-035 rst_n=0 asserted at h=1000, v=50 SHALL clear all outputs on the next edge, with newframe one edge after release; the serration build SHALL show sync low for the last 226 clocks of line 0.

Source files
------------

// File: rtl/common.sv
// Shared video-standard definitions for the composite video path.
package common;

  typedef enum logic [1:0] {
    STD_PAL   = 2'd0,
    STD_NTSC  = 2'd1,
    STD_SECAM = 2'd2
  } video_standard_e;

  localparam int H_W = 12;
  localparam int V_W = 9;

  // Lines per frame for each standard (SECAM shares the PAL raster).
  localparam logic [V_W-1:0] LINES_PAL  = 9'd312;
  localparam logic [V_W-1:0] LINES_NTSC = 9'd262;

  function automatic logic [V_W-1:0] lines_for(input video_standard_e s);
    return (s == STD_NTSC) ? LINES_NTSC : LINES_PAL;
  endfunction

endpackage

// File: rtl/timing_counter.sv
// Horizontal/vertical raster counters with per-frame standard latch.
// The standard is sampled only at h=0,v=0 so a frame never changes length
// part way through.
module timing_counter
  import common::*;
#(
  parameter int LINE_TICKS_PAL  = 3072,
  parameter int LINE_TICKS_NTSC = 3051
) (
  input  logic            clk,
  input  logic            rst_n,
  input  video_standard_e std_i,
  output logic [H_W-1:0]  h_o,
  output logic [V_W-1:0]  v_o,
  output video_standard_e std_o
);

  localparam logic [H_W-1:0] PAL_LAST  = H_W'(LINE_TICKS_PAL - 1);
  localparam logic [H_W-1:0] NTSC_LAST = H_W'(LINE_TICKS_NTSC - 1);

  logic [H_W-1:0]  h_q, h_d;
  logic [V_W-1:0]  v_q, v_d;
  video_standard_e std_q, std_d;
  logic [H_W-1:0]  h_last;
  logic [V_W-1:0]  v_last;

  // Next-state: advance h, wrap into v at end of line, wrap v at end of frame.
  always_comb begin
    std_d  = std_q;
    h_last = (std_q == STD_NTSC) ? NTSC_LAST : PAL_LAST;
    v_last = lines_for(std_q) - 9'd1;
    h_d    = h_q + 12'd1;
    v_d    = v_q;
    if (h_q == '0 && v_q == '0) begin
      std_d = std_i;
    end
    if (h_q == h_last) begin
      h_d = '0;
      v_d = (v_q == v_last) ? '0 : v_q + 9'd1;
    end
  end

  // Counter and latched-standard registers; reset also captures the standard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      std_q <= std_i;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      std_q <= std_d;
    end
  end

  assign h_o   = h_q;
  assign v_o   = v_q;
  assign std_o = std_q;

endmodule

// File: rtl/composite_video_timing.sv
// Composite video raster timing: sync/burst strobes for the encoder and
// pixel requests for the framebuffer. All outputs are registered decodes of
// the (h,v) counter state, one clock behind it.
// Optional build macro CONFIG_TIMING_SERRATION_EN: broad vsync pulses with
// serration gaps instead of solid sync on the vertical sync lines.
module composite_video_timing
  import common::*;
#(
  parameter int LINE_TICKS_PAL  = 3072,
  parameter int LINE_TICKS_NTSC = 3051,
  parameter int HSYNC_TICKS     = 226,
  parameter int BURST_START     = 269,
  parameter int ACTIVE_START    = 500,
  parameter int ACTIVE_WIDTH    = 2400,
  parameter int VSYNC_LINES     = 3,
  parameter int VBLANK_LINES    = 20,
  parameter int ACTIVE_LINES    = 240
) (
  input  logic            clk,
  input  logic            rst_n,
  input  video_standard_e video_standard,
  output logic            sync,
  output logic            newframe,
  output logic            newline,
  output logic            qam_startburst,
  output logic            secam_enabled,
  output logic            active,
  output logic [11:0]     x,
  output logic [8:0]      y
);

  localparam logic [H_W-1:0] HSYNC_H   = H_W'(HSYNC_TICKS);
  localparam logic [H_W-1:0] BURST_H   = H_W'(BURST_START);
  localparam logic [H_W-1:0] ACT_H0    = H_W'(ACTIVE_START);
  localparam logic [H_W-1:0] ACT_H1    = H_W'(ACTIVE_START + ACTIVE_WIDTH);
  localparam logic [V_W-1:0] VSYNC_V   = V_W'(VSYNC_LINES);
  localparam logic [V_W-1:0] ACT_V0    = V_W'(VBLANK_LINES);
  localparam logic [V_W-1:0] ACT_V1    = V_W'(VBLANK_LINES + ACTIVE_LINES);
`ifdef CONFIG_TIMING_SERRATION_EN
  localparam logic [H_W-1:0] BROAD_PAL  = H_W'(LINE_TICKS_PAL - HSYNC_TICKS);
  localparam logic [H_W-1:0] BROAD_NTSC = H_W'(LINE_TICKS_NTSC - HSYNC_TICKS);
`endif

  logic [H_W-1:0]  h;
  logic [V_W-1:0]  v;
  video_standard_e std;

  timing_counter #(
    .LINE_TICKS_PAL (LINE_TICKS_PAL),
    .LINE_TICKS_NTSC(LINE_TICKS_NTSC)
  ) u_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .std_i(video_standard),
    .h_o  (h),
    .v_o  (v),
    .std_o(std)
  );

  logic        sync_q, sync_d;
  logic        newframe_q, newframe_d;
  logic        newline_q, newline_d;
  logic        burst_q, burst_d;
  logic        secam_q, secam_d;
  logic        active_q, active_d;
  logic [11:0] x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        vsync_line;

  // Decode the current counter state into next-clock output values.
  always_comb begin
    vsync_line = (v < VSYNC_V);
    newline_d  = (h == '0);
    newframe_d = (h == '0) && (v == '0);
    if (vsync_line) begin
`ifdef CONFIG_TIMING_SERRATION_EN
      sync_d = (h < ((std == STD_NTSC) ? BROAD_NTSC : BROAD_PAL));
`else
      sync_d = 1'b1;
`endif
    end else begin
      sync_d = (h < HSYNC_H);
    end
    burst_d  = (h == BURST_H) && !vsync_line && (std != STD_SECAM);
    secam_d  = (std == STD_SECAM) && !vsync_line && (h >= BURST_H);
    active_d = (h >= ACT_H0) && (h < ACT_H1) && (v >= ACT_V0) && (v < ACT_V1);
    x_d      = active_d ? (h - ACT_H0) : '0;
    y_d      = active_d ? (v - ACT_V0) : '0;
  end

  // Output registers; reset clears every strobe and the pixel request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= 1'b0;
      newframe_q <= 1'b0;
      newline_q  <= 1'b0;
      burst_q    <= 1'b0;
      secam_q    <= 1'b0;
      active_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      sync_q     <= sync_d;
      newframe_q <= newframe_d;
      newline_q  <= newline_d;
      burst_q    <= burst_d;
      secam_q    <= secam_d;
      active_q   <= active_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign sync           = sync_q;
  assign newframe       = newframe_q;
  assign newline        = newline_q;
  assign qam_startburst = burst_q;
  assign secam_enabled  = secam_q;
  assign active         = active_q;
  assign x              = x_q;
  assign y              = y_q;

endmodule

// File: tb/tb_composite_video_timing.sv
// Bench for composite_video_timing with a scaled-down raster
// (48/46 clocks per line) so several full frames run quickly.
module tb_composite_video_timing;
  import common::*;

  localparam int LTP = 48;
  localparam int LTN = 46;
  localparam int HS  = 8;
  localparam int BS  = 12;
  localparam int AS  = 16;
  localparam int AW  = 24;
  localparam int VSL = 3;
  localparam int VBL = 20;
  localparam int AL  = 240;
`ifdef CONFIG_TIMING_SERRATION_EN
  localparam logic SERR_TAIL = 1'b0;
`else
  localparam logic SERR_TAIL = 1'b1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  video_standard_e vs = STD_PAL;
  logic            sync, newframe, newline, qam, secam, active;
  logic [11:0]     x;
  logic [8:0]      y;

  composite_video_timing #(
    .LINE_TICKS_PAL(LTP), .LINE_TICKS_NTSC(LTN), .HSYNC_TICKS(HS),
    .BURST_START(BS), .ACTIVE_START(AS), .ACTIVE_WIDTH(AW),
    .VSYNC_LINES(VSL), .VBLANK_LINES(VBL), .ACTIVE_LINES(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .video_standard(vs),
    .sync(sync), .newframe(newframe), .newline(newline),
    .qam_startburst(qam), .secam_enabled(secam),
    .active(active), .x(x), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v; int h;
    logic sync; logic nf; logic nl; logic qam; logic secam; logic act;
    int x; int y;
  } vec_t;

  logic [26:0] sbq[$];
  vec_t        tbl[13];
  int n_cmp = 0, n_bad = 0;
  int m_h = 0, m_v = 0;
  video_standard_e m_std = STD_PAL;
  int last_dh = -1, last_dv = -1;
  int cyc = 0, nf_cyc = -1, nl_cnt = 0;
  int flen[$], fnl[$];

  function automatic logic [26:0] pk(input logic s, nf, nl, q, se, a,
                                     input int xx, input int yy);
    logic [11:0] xv;
    logic [8:0]  yv;
    xv = 12'(xx);
    yv = 9'(yy);
    return {s, nf, nl, q, se, a, xv, yv};
  endfunction

  function automatic logic [26:0] dut_pk();
    return {sync, newframe, newline, qam, secam, active, x, y};
  endfunction

  // Reference decode of a raster position, written straight from the timing rules.
  function automatic logic [26:0] model(input int h, input int v, input video_standard_e s);
    int lt;
    logic sy, act;
    lt = (s == STD_NTSC) ? LTN : LTP;
    if (v < VSL) begin
`ifdef CONFIG_TIMING_SERRATION_EN
      sy = (h < lt - HS);
`else
      sy = 1'b1;
`endif
    end else sy = (h < HS);
    act = (h >= AS) && (h < AS + AW) && (v >= VBL) && (v < VBL + AL);
    return pk(sy, h == 0 && v == 0, h == 0,
              h == BS && v >= VSL && s != STD_SECAM,
              s == STD_SECAM && v >= VSL && h >= BS,
              act, act ? h - AS : 0, act ? v - VBL : 0);
  endfunction

  function automatic vec_t mk(input int v, h, input logic s, nf, nl, q, se, a,
                              input int xx, yy);
    vec_t r;
    r.v = v; r.h = h; r.sync = s; r.nf = nf; r.nl = nl; r.qam = q;
    r.secam = se; r.act = a; r.x = xx; r.y = yy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: push expectation, advance the model, compare the DUT output.
  task automatic tick();
    int lt, ln;
    logic [26:0] e;
    if (rst_n) begin
      sbq.push_back(model(m_h, m_v, m_std));
      last_dh = m_h;
      last_dv = m_v;
    end else begin
      sbq.push_back('0);
      last_dh = -1;
      last_dv = -1;
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_std = vs;
    end else begin
      if (m_h == 0 && m_v == 0) m_std = vs;
      lt = (m_std == STD_NTSC) ? LTN : LTP;
      ln = (m_std == STD_NTSC) ? 262 : 312;
      if (m_h == lt - 1) begin
        m_h = 0;
        m_v = (m_v == ln - 1) ? 0 : m_v + 1;
      end else m_h++;
    end
    #1;
    e = sbq.pop_front();
    chk("scoreboard", {5'd0, dut_pk()}, {5'd0, e});
    if (!rst_n) nf_cyc = -1;
    if (newframe === 1'b1) begin
      if (nf_cyc >= 0) begin
        flen.push_back(cyc - nf_cyc);
        fnl.push_back(nl_cnt);
      end
      nf_cyc = cyc;
      nl_cnt = 0;
    end
    if (newline === 1'b1) nl_cnt++;
  endtask

  task automatic run_to(input int v, input int h);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(last_dv == v && last_dh == h) && n < 40000);
    if (n >= 40000) chk($sformatf("run_to_v%0d_h%0d", v, h), 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0]  = mk(0,   0,  1, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0,   39, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0,   47, SERR_TAIL, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1,   0,  1, 0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(3,   7,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(3,   8,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(3,   12, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(19,  20, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(20,  16, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(100, 30, 0, 0, 0, 0, 0, 1, 14, 80);
    tbl[10] = mk(259, 39, 0, 0, 0, 0, 0, 1, 23, 239);
    tbl[11] = mk(259, 40, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(260, 20, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held: everything low.
    for (int i = 0; i < 3; i++) tick();
    chk("reset_outputs", {5'd0, dut_pk()}, 32'd0);

    // PAL frame walked through the table; switch to NTSC mid-frame at line 100.
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      run_to(tbl[i].v, tbl[i].h);
      chk($sformatf("vec%0d_v%0d_h%0d", i, tbl[i].v, tbl[i].h), {5'd0, dut_pk()},
          {5'd0, pk(tbl[i].sync, tbl[i].nf, tbl[i].nl, tbl[i].qam, tbl[i].secam,
                    tbl[i].act, tbl[i].x, tbl[i].y)});
      if (tbl[i].v == 100) vs = STD_NTSC;
    end

    // NTSC frame: burst strobe on line 3 at h=BURST_START, then request SECAM.
    run_to(3, 11);
    chk("ntsc_pre_burst", {31'd0, qam}, 32'd0);
    run_to(3, 12);
    chk("ntsc_burst", {31'd0, qam}, 32'd1);
    vs = STD_SECAM;

    // SECAM frame: enable rises at h=BURST_START on line 3, no burst strobe.
    run_to(3, 11);
    chk("secam_pre", {30'd0, secam, qam}, 32'd0);
    tick();
    chk("secam_rise", {30'd0, secam, qam}, 32'd2);

    chk("pal_frame_len",  flen.size() > 0 ? flen[0] : -1, LTP * 312);
    chk("pal_lines",      fnl.size()  > 0 ? fnl[0]  : -1, 312);
    chk("ntsc_frame_len", flen.size() > 1 ? flen[1] : -1, LTN * 262);
    chk("ntsc_lines",     fnl.size()  > 1 ? fnl[1]  : -1, 262);

    // Mid-line reset aborts the frame; release restarts at h=0,v=0.
    run_to(50, 20);
    rst_n = 1'b0;
    tick();
    chk("midreset_clear", {5'd0, dut_pk()}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("release_frame", {5'd0, dut_pk()}, {5'd0, pk(1, 1, 1, 0, 0, 0, 0, 0)});
    tick();
    chk("release_h1", {29'd0, newframe, newline, sync}, 32'd1);
    for (int i = 0; i < 60; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
